// File: rtl/move_issuer.sv
// Pops the sorted move list head and streams it to the search controller; flushes on cutoff.
// First move valid 3 cycles after gen_done, one move per 2 cycles; a move is held until ready.
module move_issuer #(
    parameter int MAX_LEN    = 32,
    parameter int KEY_BITS   = 8,
    parameter int VALUE_BITS = 15,
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  gen_done_in,
    input  logic                  cutoff_in,
    input  logic [VALUE_BITS-1:0] head_value_in,
    input  logic [KEY_BITS-1:0]   head_key_in,
    input  logic [LW-1:0]         len_in,
    output logic                  dequeue_out,
    output logic [VALUE_BITS-1:0] move_out,
    output logic [KEY_BITS-1:0]   move_key_out,
    output logic                  move_valid_out,
    input  logic                  move_ready_in,
    output logic                  done_out,
    output logic                  done_cut_out,
    output logic [LW-1:0]         issued_count_out,
    output logic                  busy_out
);

    typedef enum logic [2:0] {
        IDLE, FILL, SETTLE, LOAD, ISSUE, FLUSH, DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  cut_q, cut_d;
    logic                  done_cut_q, done_cut_d;
    logic [LW-1:0]         count_q, count_d;
    logic [VALUE_BITS-1:0] move_q, move_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic                  len_nz;

    assign len_nz = (len_in != '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            cut_q      <= 1'b0;
            done_cut_q <= 1'b0;
            count_q    <= '0;
            move_q     <= '0;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            cut_q      <= cut_d;
            done_cut_q <= done_cut_d;
            count_q    <= count_d;
            move_q     <= move_d;
            key_q      <= key_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cut_d       = cut_q;
        done_cut_d  = done_cut_q;
        count_d     = count_q;
        move_d      = move_q;
        key_d       = key_q;
        dequeue_out = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    count_d    = '0;
                    cut_d      = 1'b0;
                    done_cut_d = 1'b0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                // Cutoff is only remembered here so flushing never races generator inserts.
                if (cutoff_in) cut_d = 1'b1;
                if (gen_done_in) state_d = SETTLE;
            end
            SETTLE: begin
                if (cut_q || cutoff_in) begin
                    cut_d   = 1'b1;
                    state_d = FLUSH;
                end else if (len_nz) begin
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            LOAD: begin
                dequeue_out = 1'b1;
                move_d      = head_value_in;
                key_d       = head_key_in;
                if (cutoff_in) begin
                    cut_d   = 1'b1;
                    state_d = FLUSH;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (move_ready_in && (count_q != LW'(MAX_LEN))) count_d = count_q + 1'b1;
                if (cutoff_in) begin
                    cut_d   = 1'b1;
                    state_d = FLUSH;
                end else if (move_ready_in) begin
                    state_d = len_nz ? LOAD : DONE;
                end
            end
            FLUSH: begin
                dequeue_out = len_nz;
                if (!len_nz) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) done_cut_d = cut_d;
    end

    assign move_out         = move_q;
    assign move_key_out     = key_q;
    assign move_valid_out   = (state_q == ISSUE);
    assign done_out         = (state_q == DONE);
    assign done_cut_out     = done_cut_q;
    assign issued_count_out = count_q;
    assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_move_issuer.sv
module tb_move_issuer;
    localparam int MAX_LEN = 32;
    localparam int KB = 8;
    localparam int VB = 15;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_in, gen_done_in, cutoff_in, move_ready_in;
    logic [VB-1:0] head_value_in;
    logic [KB-1:0] head_key_in;
    logic [LW-1:0] len_in;
    logic          dequeue_out, move_valid_out, done_out, done_cut_out, busy_out;
    logic [VB-1:0] move_out;
    logic [KB-1:0] move_key_out;
    logic [LW-1:0] issued_count_out;

    logic          ins_vld;
    logic [KB-1:0] ins_key;
    logic [VB-1:0] ins_val;

    always #5 clk = ~clk;

    move_issuer #(.MAX_LEN(MAX_LEN), .KEY_BITS(KB), .VALUE_BITS(VB)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_in), .gen_done_in(gen_done_in),
        .cutoff_in(cutoff_in), .head_value_in(head_value_in), .head_key_in(head_key_in),
        .len_in(len_in), .dequeue_out(dequeue_out), .move_out(move_out),
        .move_key_out(move_key_out), .move_valid_out(move_valid_out),
        .move_ready_in(move_ready_in), .done_out(done_out), .done_cut_out(done_cut_out),
        .issued_count_out(issued_count_out), .busy_out(busy_out)
    );

    // Sorter stand-in: descending-key list with registered head and length.
    logic [KB-1:0] sk[$];
    logic [VB-1:0] sv[$];
    int            p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk.delete();
            sv.delete();
            len_in        <= '0;
            head_key_in   <= '0;
            head_value_in <= '0;
        end else begin
            if (dequeue_out && sk.size() > 0) begin
                void'(sk.pop_front());
                void'(sv.pop_front());
            end
            if (ins_vld) begin
                p = 0;
                while (p < sk.size() && sk[p] >= ins_key) p++;
                sk.insert(p, ins_key);
                sv.insert(p, ins_val);
            end
            len_in        <= LW'(sk.size());
            head_key_in   <= (sk.size() > 0) ? sk[0] : '0;
            head_value_in <= (sv.size() > 0) ? sv[0] : '0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [KB-1:0] stim_k[$];
    logic [VB-1:0] stim_v[$];
    logic [KB-1:0] exp_k[$];
    logic [VB-1:0] exp_v[$];
    int n_deq, n_acc, n_done, t_done, t_first_v;
    bit stall, drop_chk;
    logic [VB-1:0] pv;
    logic [KB-1:0] pk;

    task automatic gen_stim(input int n);
        logic [KB-1:0] k;
        bit dup;
        stim_k.delete();
        stim_v.delete();
        for (int i = 0; i < n; i++) begin
            do begin
                k = KB'($urandom_range(1, 255));
                dup = 0;
                foreach (stim_k[j]) if (stim_k[j] == k) dup = 1;
            end while (dup);
            stim_k.push_back(k);
            stim_v.push_back(VB'($urandom_range(0, 32767)));
        end
    endtask

    task automatic clr_inputs();
        start_in = 0; gen_done_in = 0; cutoff_in = 0; ins_vld = 0;
    endtask

    // Called after this cycle's inputs are applied; they hold until the next rising edge.
    task automatic observe();
        if (stall) begin
            chk("hold_valid", int'(move_valid_out), 1);
            chk("hold_move", int'(move_out), int'(pv));
            chk("hold_key", int'(move_key_out), int'(pk));
        end
        if (drop_chk) chk("valid_drop_after_cut", int'(move_valid_out), 0);
        stall    = move_valid_out && !move_ready_in && !cutoff_in;
        drop_chk = move_valid_out && cutoff_in;
        pv = move_out;
        pk = move_key_out;
        if (dequeue_out) n_deq++;
        if (move_valid_out && t_first_v < 0) t_first_v = cyc;
        if (move_valid_out && move_ready_in) begin
            if (exp_k.size() == 0) begin
                chk("extra_move", 1, 0);
            end else begin
                chk("move_key", int'(move_key_out), int'(exp_k[0]));
                chk("move_val", int'(move_out), int'(exp_v[0]));
                void'(exp_k.pop_front());
                void'(exp_v.pop_front());
            end
            n_acc++;
        end
        if (done_out) begin
            n_done++;
            t_done = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        clr_inputs();
    endtask

    // cmode: 0 none, 1 cutoff in FILL, 2 cutoff while move #cj is offered, 3 cutoff in SETTLE.
    task automatic run_node(input int n, input int cmode, input int cj, input int cut_rdy,
                            input int rdy_pct, input int stall_n, input int exp_acc, input bit exp_cut);
        int t_gd, stall_left;
        bit cut_sent;
        logic [KB-1:0] tk;
        logic [VB-1:0] tv;
        n_deq = 0; n_acc = 0; n_done = 0; t_done = -1; t_first_v = -1;
        stall = 0; drop_chk = 0; cut_sent = 0; stall_left = stall_n; t_gd = 0;
        exp_k = stim_k;
        exp_v = stim_v;
        for (int i = 0; i < exp_k.size(); i++)
            for (int j = i + 1; j < exp_k.size(); j++)
                if (exp_k[j] > exp_k[i]) begin
                    tk = exp_k[i]; exp_k[i] = exp_k[j]; exp_k[j] = tk;
                    tv = exp_v[i]; exp_v[i] = exp_v[j]; exp_v[j] = tv;
                end
        tick(); start_in = 1; move_ready_in = 1; observe();
        tick(); cutoff_in = (cmode == 1); observe();
        for (int i = 0; i < n; i++) begin
            tick();
            ins_vld = 1; ins_key = stim_k[i]; ins_val = stim_v[i];
            if (i == n - 1) begin gen_done_in = 1; t_gd = cyc; end
            observe();
        end
        if (n == 0) begin tick(); gen_done_in = 1; t_gd = cyc; observe(); end
        chk("fill_no_dequeue", n_deq, 0);
        for (int c = 0; c < 400 && n_done == 0; c++) begin
            tick();
            move_ready_in = ($urandom_range(0, 99) < rdy_pct);
            if (move_valid_out && stall_left > 0) begin move_ready_in = 0; stall_left--; end
            if (cmode == 3 && cyc == t_gd + 1) cutoff_in = 1;
            if (cmode == 2 && !cut_sent && move_valid_out && n_acc == cj) begin
                cutoff_in = 1; move_ready_in = cut_rdy[0]; cut_sent = 1;
            end
            observe();
        end
        if (n_done == 0) chk("done_timeout", 0, 1);
        tick(); observe();
        chk("done_single_pulse", n_done, 1);
        chk("idle_not_busy", int'(busy_out), 0);
        chk("dequeue_total", n_deq, n);
        chk("accepted", n_acc, exp_acc);
        chk("issued_count", int'(issued_count_out), exp_acc);
        chk("done_cut", int'(done_cut_out), int'(exp_cut));
        if (n > 0 && (cmode == 0 || cmode == 2)) chk("first_valid_lat", t_first_v - t_gd, 3);
        if (!exp_cut && rdy_pct == 100 && stall_n == 0) chk("done_lat", t_done - t_gd, 2 + 2 * n);
    endtask

    typedef struct {
        int n; int cmode; int cj; int cut_rdy; int rdy; int stall_n; int exp_acc; bit exp_cut;
    } vec_t;
    vec_t vt[10];

    initial begin
        int n, cmode, cj, cut_rdy, rdy, eacc;
        bit ecut;
        vt[0] = '{0,  0, 0, 0, 100, 0, 0,  0};
        vt[1] = '{3,  0, 0, 0, 100, 0, 3,  0};
        vt[2] = '{3,  0, 0, 0, 100, 5, 3,  0};
        vt[3] = '{5,  2, 0, 1, 100, 0, 1,  1};
        vt[4] = '{5,  2, 2, 0, 60,  0, 2,  1};
        vt[5] = '{2,  1, 0, 0, 100, 0, 0,  1};
        vt[6] = '{0,  1, 0, 0, 100, 0, 0,  1};
        vt[7] = '{4,  3, 0, 0, 100, 0, 0,  1};
        vt[8] = '{32, 0, 0, 0, 100, 0, 32, 0};
        vt[9] = '{4,  2, 3, 1, 50,  0, 4,  1};

        clr_inputs();
        move_ready_in = 0; ins_key = '0; ins_val = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_dequeue", int'(dequeue_out), 0);
        chk("rst_valid", int'(move_valid_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_done_cut", int'(done_cut_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_move", int'(move_out), 0);
        chk("rst_key", int'(move_key_out), 0);
        chk("rst_count", int'(issued_count_out), 0);
        rst_n = 1;

        stim_k = {8'd2, 8'd9, 8'd5};
        stim_v = {15'd100, 15'd200, 15'd300};
        run_node(3, 0, 0, 0, 100, 0, 3, 0);

        for (int i = 0; i < 10; i++) begin
            gen_stim(vt[i].n);
            run_node(vt[i].n, vt[i].cmode, vt[i].cj, vt[i].cut_rdy, vt[i].rdy,
                     vt[i].stall_n, vt[i].exp_acc, vt[i].exp_cut);
        end

        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 12);
            cmode = $urandom_range(0, 3);
            cj = (n > 0) ? $urandom_range(0, n - 1) : 0;
            cut_rdy = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0: rdy = 100;
                1: rdy = 60;
                default: rdy = 30;
            endcase
            eacc = n; ecut = 0;
            if (cmode == 1 || cmode == 3) begin eacc = 0; ecut = 1; end
            if (cmode == 2 && n > 0) begin eacc = cj + cut_rdy; ecut = 1; end
            gen_stim(n);
            run_node(n, cmode, cj, cut_rdy, rdy, 0, eacc, ecut);
        end

        gen_stim(3);
        tick(); start_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ins_vld = 1; ins_key = stim_k[i]; ins_val = stim_v[i];
            gen_done_in = (i == 2);
        end
        tick(); move_ready_in = 0;
        for (int i = 0; i < 20 && !move_valid_out; i++) @(negedge clk);
        chk("rst_mid_pre_valid", int'(move_valid_out), 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_valid", int'(move_valid_out), 0);
        chk("rst_mid_busy", int'(busy_out), 0);
        chk("rst_mid_move", int'(move_out), 0);
        chk("rst_mid_key", int'(move_key_out), 0);
        chk("rst_mid_dequeue", int'(dequeue_out), 0);
        @(negedge clk);
        rst_n = 1;
        gen_stim(3);
        run_node(3, 0, 0, 0, 100, 0, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/move_issuer.md
# move_issuer

Downstream consumer of the sorted move list. Once the move generator has finished inserting scored moves into the sorter, it pops the list head one entry at a time and presents it to the search controller on a valid/ready stream. It also handles beta cutoffs by flushing the remaining entries, and it signals completion of each node's move list.

## Interface
Parameters:
- MAX_LEN, 32, sorter capacity in entries.
- KEY_BITS, 8, score width.
- VALUE_BITS, 15, encoded move width.

Ports:
- clk_in  input  1  system clock; all state changes on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse that begins a new node; honoured only in IDLE.
- gen_done_in  input  1  one-cycle pulse from the generator after (or coincident with) its last insertion.
- cutoff_in  input  1  one-cycle pulse from the search that abandons the remaining moves.
- head_value_in  input  VALUE_BITS  sorter entry 0 (move).
- head_key_in  input  KEY_BITS  sorter entry 0 (score).
- len_in  input  $clog2(MAX_LEN+1)  registered sorter occupancy.
- dequeue_out  output  1  sorter pop strobe (combinational).
- move_out  output  VALUE_BITS  issued move (registered).
- move_key_out  output  KEY_BITS  score of the issued move (registered).
- move_valid_out  output  1  stream valid.
- move_ready_in  input  1  stream ready.
- done_out  output  1  one-cycle pulse when the node's list is exhausted or flushed.
- done_cut_out  output  1  qualifies done_out: 1 means the list ended by cutoff; held until the next start.
- issued_count_out  output  $clog2(MAX_LEN+1)  moves accepted since start; saturates at MAX_LEN.
- busy_out  output  1  high in every state except IDLE.

## Operation
- States: IDLE, FILL, SETTLE, LOAD, ISSUE, FLUSH, DONE.
- IDLE:
  - start_in: clear issued_count_out and the cut flag, go to FILL.
  - start_in is ignored in all other states.
- FILL: wait for gen_done_in, then go to SETTLE. The settle cycle lets a coincident final insertion reach len_in.
- SETTLE: exit in this priority order:
  - cut flag set: go to FLUSH.
  - len_in != 0: go to LOAD.
  - otherwise: go to DONE.
- LOAD:
  - Capture head_value_in/head_key_in into move_out/move_key_out.
  - dequeue_out=1.
  - Go to ISSUE.
- ISSUE:
  - move_valid_out=1; move_out and move_key_out are held stable until the handshake.
  - On move_valid_out&move_ready_in: increment issued_count_out (saturating), then go to LOAD if len_in != 0, else DONE. len_in already reflects the LOAD pop at this point.
- FLUSH:
  - dequeue_out = (len_in != 0).
  - When len_in == 0, go to DONE.
- DONE: done_out=1 for one cycle, then go to IDLE.
- cutoff_in handling:
  - In FILL: sets a sticky cut flag; it is acted on in SETTLE, so flushing never overlaps generator insertions.
  - In SETTLE, LOAD or ISSUE: set the cut flag and go directly to FLUSH. move_valid_out drops in the next cycle. An ISSUE handshake in the same cycle as cutoff still counts; cutoff still wins the transition.
  - In IDLE, FLUSH or DONE: ignored.
- dequeue_out = (state==LOAD) | (state==FLUSH & len_in!=0). It is never asserted in IDLE, FILL or SETTLE.
- done_cut_out takes the cut flag's value and holds until the next accepted start_in.

## Timing
- Reset values: state IDLE; dequeue_out, move_valid_out, done_out, done_cut_out, busy_out = 0; move_out, move_key_out, issued_count_out = 0; cut flag = 0.
- Reset asserted mid-operation returns the block to IDLE at once. The sorter is not flushed by this block; it must be reset alongside.
- Latency:
  - gen_done_in at cycle t: SETTLE at t+1, LOAD at t+2, first move_valid_out at t+3.
  - Throughput: one move per 2 cycles with ready held high.
- Empty list: gen_done_in at t gives done_out at t+2 with done_cut_out=0.
- Flush: takes len_in cycles of dequeue_out, then one DONE cycle.
- Full list: len_in=MAX_LEN is represented without wrap. issued_count_out stops at MAX_LEN.

## Test plan
- Empty node: start, then gen_done with len_in=0 -> done_out exactly 2 cycles after gen_done; issued_count_out=0; no dequeue_out.
- Three entries with keys 9,5,2 and ready always high -> moves issued in order 9,5,2, spaced 2 cycles apart; 3 dequeue pulses; done_out with done_cut_out=0; issued_count_out=3.
- Backpressure: ready low for 5 cycles during ISSUE -> move_out stable and valid held; no extra dequeue_out.
- Cutoff after the first handshake with 4 entries remaining -> valid drops next cycle; exactly 4 FLUSH dequeue pulses; done_out with done_cut_out=1; issued_count_out=1.
- cutoff_in during FILL, then gen_done with len_in=2 -> no move issued; 2 dequeue pulses; done_cut_out=1.
- rst_n_in low during ISSUE -> all outputs zero immediately; start_in after release is accepted normally.
